// File: rtl/gated_capture_sequencer_if.sv
// Control/config and capture-result signals of the gated capture sequencer.
// master drives the controls; slave is the sequencer.
interface gated_capture_sequencer_if #(
  parameter int unsigned WIN_W = 8,
  parameter int unsigned CNT_W = 8
);
  logic             cfg_we;
  logic             cfg_gate;
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] win_len;
  logic             data;
  logic             sample;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output cfg_we, cfg_gate, start, abort, win_len, data,
    input  sample, count, busy, done
  );

  modport slave (
    input  cfg_we, cfg_gate, start, abort, win_len, data,
    output sample, count, busy, done
  );
endinterface

// File: rtl/gated_capture_sequencer.sv
// Sequences a gated sampling window: counts gate & data over win_len capture cycles,
// then pulses done. The gate register is reset to 1 and only writable when not busy.
module gated_capture_sequencer #(
  parameter int unsigned WIN_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gated_capture_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArm, StCapture, StDone} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [WIN_W-1:0] RemLast = WIN_W'(1);

  state_e           state_q, state_d;
  logic             gate_q, gate_d;
  logic [WIN_W-1:0] remaining_q, remaining_d;
  logic             sample_q, sample_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gate_q      <= 1'b1;
      remaining_q <= '0;
      sample_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      gate_q      <= gate_d;
      remaining_q <= remaining_d;
      sample_q    <= sample_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gate_d      = gate_q;
    remaining_d = remaining_q;
    sample_d    = sample_q;
    count_d     = count_q;
    hit         = gate_q & bus.data;

    unique case (state_q)
      StIdle: begin
        if (bus.cfg_we) begin
          gate_d = bus.cfg_gate;
        end
        // abort wins over a simultaneous start
        if (bus.start && !bus.abort) begin
          count_d  = '0;
          sample_d = 1'b0;
          if (bus.win_len != '0) begin
            state_d     = StArm;
            remaining_d = bus.win_len;
          end else begin
            state_d = StDone;
          end
        end
      end
      StArm: begin
        state_d = bus.abort ? StIdle : StCapture;
      end
      StCapture: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          sample_d    = hit;
          remaining_d = remaining_q - RemLast;
          if (hit && (count_q != CntMax)) begin
            count_d = count_q + CNT_W'(1);
          end
          if (remaining_q == RemLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.cfg_we) begin
          gate_d = bus.cfg_gate;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.sample = sample_q;
  assign bus.count  = count_q;
  assign bus.busy   = (state_q == StArm) || (state_q == StCapture);
  assign bus.done   = (state_q == StDone);

endmodule

// File: tb/tb_gated_capture_sequencer.sv
// Bench for gated_capture_sequencer: a CNT_W=8 and a CNT_W=2 instance share stimulus;
// directed window table, hand corner sequences, then random traffic against a window model.
module tb_gated_capture_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic       cfg_gate = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] win_len = 8'd0;
  logic       data = 1'b0;

  int checks = 0;
  int errors = 0;

  gated_capture_sequencer_if #(.WIN_W(8), .CNT_W(8)) bus8 ();
  gated_capture_sequencer_if #(.WIN_W(8), .CNT_W(2)) bus2 ();

  assign bus8.cfg_we = cfg_we;   assign bus2.cfg_we = cfg_we;
  assign bus8.cfg_gate = cfg_gate; assign bus2.cfg_gate = cfg_gate;
  assign bus8.start = start;     assign bus2.start = start;
  assign bus8.abort = abort;     assign bus2.abort = abort;
  assign bus8.win_len = win_len; assign bus2.win_len = win_len;
  assign bus8.data = data;       assign bus2.data = data;

  gated_capture_sequencer #(.WIN_W(8), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  gated_capture_sequencer #(.WIN_W(8), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  // Window model: m_age < 0 means no window open; age 0 is the settle cycle,
  // ages 1..len are capture edges.
  bit m_gate;
  int m_age;
  int m_len;
  bit m_done;
  bit m_sample;
  int m_cnt8;
  int m_cnt2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_gate = 1'b1; m_age = -1; m_len = 0; m_done = 1'b0;
    m_sample = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
  endfunction

  function automatic void model_step();
    bit nd = 1'b0;
    bit s;
    if (m_age < 0) begin
      if (cfg_we) m_gate = cfg_gate;
      if (!m_done && start && !abort) begin
        m_cnt8 = 0; m_cnt2 = 0; m_sample = 1'b0;
        if (win_len == 0) nd = 1'b1;
        else begin
          m_age = 0; m_len = int'(win_len);
        end
      end
    end else if (abort) begin
      m_age = -1;
    end else if (m_age == 0) begin
      m_age = 1;
    end else begin
      s = m_gate & data;
      m_sample = s;
      m_cnt8 = (m_cnt8 + s > 255) ? 255 : m_cnt8 + s;
      m_cnt2 = (m_cnt2 + s > 3) ? 3 : m_cnt2 + s;
      if (m_age == m_len) begin
        m_age = -1; nd = 1'b1;
      end else m_age++;
    end
    m_done = nd;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("busy", bus8.busy, (m_age >= 0) ? 1 : 0);
    chk("done", bus8.done, m_done);
    chk("count8", bus8.count, m_cnt8);
    chk("count2", bus2.count, m_cnt2);
    chk("sample", bus8.sample, m_sample);
    chk("busy2", bus2.busy, bus8.busy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", bus8.busy, 0);
    chk("rst_done", bus8.done, 0);
    chk("rst_count8", bus8.count, 0);
    chk("rst_count2", bus2.count, 0);
    chk("rst_sample", bus8.sample, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit gate_wr;
    bit gate_val;
    bit wr_mid;
    int len;
    bit dat;
    int abort_at;
    int exp_cnt8;
    int exp_cnt2;
    int exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int dones;
    int lat;
    bit busy_seen;

    vecs[0] = '{0, 0, 0, 4,   1, 0, 4,   3, 5};    // gate resets to 1
    vecs[1] = '{1, 0, 0, 5,   1, 0, 0,   0, 6};    // gate forced to 0
    vecs[2] = '{1, 1, 1, 3,   1, 0, 3,   3, 4};    // write during capture dropped
    vecs[3] = '{0, 0, 0, 2,   1, 0, 2,   2, 3};    // gate still 1
    vecs[4] = '{0, 0, 0, 6,   1, 0, 6,   3, 7};    // 2-bit count saturates
    vecs[5] = '{0, 0, 0, 8,   1, 3, 2,   2, -1};   // abort at 3rd capture edge
    vecs[6] = '{0, 0, 0, 0,   1, 0, 0,   0, 0};    // zero-length window
    vecs[7] = '{0, 0, 0, 255, 1, 0, 255, 3, 256};  // full-range window

    model_reset();
    #1;
    chk("por_busy", bus8.busy, 0);
    chk("por_done", bus8.done, 0);
    chk("por_count", bus8.count, 0);
    chk("por_sample", bus8.sample, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    for (int v = 0; v < 8; v++) begin
      data = vecs[v].dat;
      if (vecs[v].gate_wr) begin
        cfg_we = 1'b1; cfg_gate = vecs[v].gate_val;
        cycle();
        cfg_we = 1'b0;
      end
      start = 1'b1; win_len = 8'(vecs[v].len);
      cycle();
      start = 1'b0;
      dones = 0; lat = -1; busy_seen = bus8.busy;
      if (bus8.done) begin dones++; lat = 0; end
      for (int n = 1; n <= vecs[v].len + 4; n++) begin
        abort = (vecs[v].abort_at != 0) && (n == vecs[v].abort_at + 1);
        cfg_we = vecs[v].wr_mid && (n == 2);
        cfg_gate = 1'b0;
        cycle();
        abort = 1'b0; cfg_we = 1'b0;
        if (bus8.busy) busy_seen = 1'b1;
        if (bus8.done) begin
          dones++;
          if (lat < 0) lat = n;
        end
      end
      chk($sformatf("v%0d_count8", v), bus8.count, vecs[v].exp_cnt8);
      chk($sformatf("v%0d_count2", v), bus2.count, vecs[v].exp_cnt2);
      chk($sformatf("v%0d_dones", v), dones, (vecs[v].exp_lat >= 0) ? 1 : 0);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      chk($sformatf("v%0d_busy_seen", v), busy_seen, (vecs[v].len != 0) ? 1 : 0);
    end

    // start together with abort in idle stays idle
    start = 1'b1; abort = 1'b1; win_len = 8'd4;
    cycle();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", bus8.busy, 0);
    cycle();
    chk("start_abort_done", bus8.done, 0);

    // reset in the middle of a capture window
    start = 1'b1; win_len = 8'd8; data = 1'b1;
    cycle();
    start = 1'b0;
    for (int n = 0; n < 4; n++) cycle();
    chk("pre_rst_busy", bus8.busy, 1);
    do_reset();
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (bus8.done) dones++;
    end
    chk("rst_no_done", dones, 0);
    start = 1'b1; win_len = 8'd3;
    cycle();
    start = 1'b0;
    for (int n = 0; n < 6; n++) cycle();
    chk("rst_gate_is_1", bus8.count, 3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 15) == 0);
      win_len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 10));
      data = 1'($urandom);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_gate = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
